// File: rtl/banked_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : banked_latch_pkg
// Brief    : Shared FSM encoding, default sizes and select-range helper.
// Revision : 1.0  initial release
// ============================================================================
package banked_latch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PRESS   = 2'd1;
    localparam state_t ST_COMMIT  = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_NUM_BANKS       = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_SCAN_CYCLES     = 1_000_000;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_banks);
        return sel < num_banks;
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_latch_register_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchroniser plus press/release debounce FSM; emits a
//            single-cycle commit pulse per accepted press.
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import banked_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic commit
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_btn_s;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_btn_s   = r_sync[1];
    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + CNT_W'(1);
    assign commit    = (r_state == ST_COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], btn};
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (w_btn_s) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            r_state <= ST_COMMIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    r_cnt   <= '0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // A re-bounce restarts the release window instead of re-arming a write.
                    if (!w_btn_s) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_LAST) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/banked_latch_register.sv
`default_nettype none
// ============================================================================
// Module   : banked_latch_register
// Brief    : NUM_BANKS x WIDTH register file written once per debounced button
//            press, with a registered read mux. Optional macro AUTO_SCAN_EN adds
//            an auto-advancing display index (scan_en / scan_idx).
// Revision : 1.0  initial release
// ============================================================================
module banked_latch_register
    import banked_latch_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int SEL_W           = $clog2(NUM_BANKS),
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_SCAN_EN
    ,
    parameter int SCAN_CYCLES     = DEF_SCAN_CYCLES
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 wr_done,
    output logic [NUM_BANKS-1:0] bank_valid
`ifdef AUTO_SCAN_EN
    ,
    input  logic                 scan_en,
    output logic [SEL_W-1:0]     scan_idx
`endif
);

    logic [WIDTH-1:0]     r_bank [NUM_BANKS];
    logic [WIDTH-1:0]     r_rd_data;
    logic                 r_wr_done;
    logic [NUM_BANKS-1:0] r_bank_valid;
    logic                 w_commit;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [SEL_W-1:0]     w_rd_idx;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .commit (w_commit)
    );

`ifdef AUTO_SCAN_EN
    localparam int               SCAN_W    = $clog2(SCAN_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_BANKS - 1);

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [SEL_W-1:0]  r_scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (scan_en) begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == SEL_LAST) ? '0 : r_scan_idx + SEL_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign scan_idx = r_scan_idx;
    assign w_rd_idx = scan_en ? r_scan_idx : rd_sel;
`else
    assign w_rd_idx = rd_sel;
`endif

    assign w_wr_ok = sel_in_range(32'(wr_sel), NUM_BANKS);
    assign w_rd_ok = sel_in_range(32'(w_rd_idx), NUM_BANKS);

    // The read samples the pre-write array, so a same-bank commit shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_bank[i] <= '0;
            end
            r_bank_valid <= '0;
            r_wr_done    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_wr_done <= w_commit;
            if (w_commit && w_wr_ok) begin
                r_bank[wr_sel]       <= wr_data;
                r_bank_valid[wr_sel] <= 1'b1;
            end
            r_rd_data <= w_rd_ok ? r_bank[w_rd_idx] : '0;
        end
    end

    assign rd_data    = r_rd_data;
    assign wr_done    = r_wr_done;
    assign bank_valid = r_bank_valid;

endmodule
`default_nettype wire

// File: tb/tb_banked_latch_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_latch_register
// Brief    : Scoreboard bench: 4-bank and 3-bank instances, debounce of 4 cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_banked_latch_register;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn, btn3;
    logic [1:0] wr_sel, wr_sel3, rd_sel, rd_sel3;
    logic [7:0] wr_data, wr_data3, rd_data, rd_data3;
    logic       wr_done, wr_done3;
    logic [3:0] bank_valid;
    logic [2:0] bank_valid3;
`ifdef AUTO_SCAN_EN
    logic       scan_en, scan_en3;
    logic [1:0] scan_idx, scan_idx3;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_done3 = 0;
    logic [7:0] model_bank [4];
    logic [3:0] model_valid;
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];

    always #5 clk = ~clk;

    banked_latch_register #(
        .WIDTH (8), .NUM_BANKS (4), .DEBOUNCE_CYCLES (4)
`ifdef AUTO_SCAN_EN
        , .SCAN_CYCLES (5)
`endif
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .btn (btn), .wr_sel (wr_sel), .wr_data (wr_data),
        .rd_sel (rd_sel), .rd_data (rd_data), .wr_done (wr_done), .bank_valid (bank_valid)
`ifdef AUTO_SCAN_EN
        , .scan_en (scan_en), .scan_idx (scan_idx)
`endif
    );

    banked_latch_register #(
        .WIDTH (8), .NUM_BANKS (3), .DEBOUNCE_CYCLES (4)
`ifdef AUTO_SCAN_EN
        , .SCAN_CYCLES (5)
`endif
    ) u_dut3 (
        .clk (clk), .rst_n (rst_n), .btn (btn3), .wr_sel (wr_sel3), .wr_data (wr_data3),
        .rd_sel (rd_sel3), .rd_data (rd_data3), .wr_done (wr_done3), .bank_valid (bank_valid3)
`ifdef AUTO_SCAN_EN
        , .scan_en (scan_en3), .scan_idx (scan_idx3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write scoreboard: each wr_done retires the oldest pending write.
    always @(negedge clk) begin : mon_wr
        wr_t w;
        if (rst_n && wr_done) begin
            n_done++;
            if (exp_wr.size() == 0) begin
                check("wr_done_unexpected", 32'(wr_done), 32'd0);
            end else begin
                w = exp_wr.pop_front();
                model_bank[w.sel]  = w.data;
                model_valid[w.sel] = 1'b1;
                check("bank_valid_on_done", 32'(bank_valid), 32'(model_valid));
            end
        end
        if (rst_n && wr_done3) n_done3++;
    end

    task automatic press(input logic [1:0] sel, input logic [7:0] d0, input logic [7:0] d1, input int hold);
        int  done0;
        wr_t w;
        done0 = n_done;
        @(negedge clk);
        wr_sel = sel; wr_data = d0; btn = 1'b1;
        w.sel = sel; w.data = d0;
        exp_wr.push_back(w);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 11) wr_data = d1;
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        check("wr_done_count", 32'(n_done - done0), 32'd1);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] sel);
        @(negedge clk);
        rd_sel = sel;
        exp_rd.push_back(model_bank[sel]);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp_rd.pop_front()));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model_bank[i] = 8'h00;
        model_valid = 4'b0000;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int  done0;
        bit  seen;
        rst_n = 1'b0; btn = 1'b0; btn3 = 1'b0;
        wr_sel = '0; wr_sel3 = '0; wr_data = '0; wr_data3 = '0; rd_sel = '0; rd_sel3 = '0;
`ifdef AUTO_SCAN_EN
        scan_en = 1'b0; scan_en3 = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_bank_valid", 32'(bank_valid), 32'd0);
        check("reset_wr_done", 32'(wr_done), 32'd0);
        rst_n = 1'b1;

        // Clean press
        press(2'd2, 8'hA5, 8'hA5, 10);
        check("valid_after_press", 32'(bank_valid), 32'h4);
        rd_check("rd_bank2", 2'd2);

        // Reset in the middle of a press
        done0 = n_done;
        @(negedge clk); btn = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd_data", 32'(rd_data), 32'd0);
        check("async_rst_bank_valid", 32'(bank_valid), 32'd0);
        clear_model();
        @(negedge clk); btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_write_after_rst", 32'(n_done - done0), 32'd0);
        check("valid_after_rst", 32'(bank_valid), 32'd0);
        rd_check("rd_bank2_after_rst", 2'd2);

        // Glitches of 2 and 3 cycles: one short of the commit threshold at most
        for (int k = 2; k <= 3; k++) begin
            done0 = n_done;
            @(negedge clk); wr_sel = 2'd0; wr_data = 8'hFF; btn = 1'b1;
            repeat (k) @(negedge clk);
            btn = 1'b0;
            repeat (10) @(negedge clk);
            check("glitch_no_done", 32'(n_done - done0), 32'd0);
            check("glitch_valid", 32'(bank_valid), 32'd0);
        end

        // Long hold with data changing after the commit
        press(2'd3, 8'h11, 8'h22, 100);
        check("valid_long_hold", 32'(bank_valid), 32'h8);
        rd_check("rd_bank3_long_hold", 2'd3);

        // Same-bank write/read collision
        @(negedge clk);
        rd_sel = 2'd1; wr_sel = 2'd1; wr_data = 8'h3C; btn = 1'b1;
        exp_wr.push_back('{sel: 2'd1, data: 8'h3C});
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (wr_done) seen = 1'b1;
        end
        if (!seen) begin
            check("collision_timeout", 32'(wr_done), 32'd1);
        end else begin
            check("collision_old", 32'(rd_data), 32'h00);
            @(negedge clk);
            check("collision_new", 32'(rd_data), 32'h3C);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);

        // 3-bank instance: one valid write then one out-of-range write
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wr_sel3 = (k == 0) ? 2'd0 : 2'd3;
            wr_data3 = (k == 0) ? 8'h5A : 8'h77;
            btn3 = 1'b1;
            repeat (10) @(negedge clk);
            btn3 = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("oor_done_count", 32'(n_done3), 32'd2);
        check("oor_valid", 32'(bank_valid3), 32'h1);
        @(negedge clk); rd_sel3 = 2'd0;
        @(negedge clk); check("oor_rd_bank0", 32'(rd_data3), 32'h5A);
        rd_sel3 = 2'd2;
        @(negedge clk); check("oor_rd_bank2", 32'(rd_data3), 32'h00);
        rd_sel3 = 2'd3;
        @(negedge clk); check("oor_rd_sel3", 32'(rd_data3), 32'h00);

`ifdef AUTO_SCAN_EN
        for (int b = 0; b < 4; b++) press(2'(b), 8'(b + 1), 8'(b + 1), 10);
        check("scan_idx_idle", 32'(scan_idx), 32'd0);
        @(negedge clk); scan_en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check("scan_idx", 32'(scan_idx), 32'((k / 5) % 4));
            check("scan_rd_data", 32'(rd_data), 32'(((k - 1) / 5) % 4 + 1));
        end
        scan_en = 1'b0;
        rd_check("rd_after_scan", 2'd2);
`endif

        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
